// File: rtl/dot_product_stage.sv
// Streaming signed MAC stage: multiplies packed operand pairs from the FIFO
// and accumulates them over a programmed length, then hands off one result.
// Ports: clkIn/rstIn (async active-low), startIn/lenIn/busyOut job control,
// rdDataIn/rdValidIn/rdReadyOut FIFO read side,
// resDataOut/resValidOut/resReadyIn/ovfOut result handshake.
module dot_product_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 48,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  startIn,
  input  logic [LEN_WIDTH-1:0]  lenIn,
  output logic                  busyOut,
  input  logic [DATA_WIDTH-1:0] rdDataIn,
  input  logic                  rdValidIn,
  output logic                  rdReadyOut,
  output logic [ACC_WIDTH-1:0]  resDataOut,
  output logic                  resValidOut,
  input  logic                  resReadyIn,
  output logic                  ovfOut
);

  localparam int HALF = DATA_WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH,
    DONE
  } state_t;

  state_t stateR;
  state_t stateNext;

  logic [LEN_WIDTH-1:0]         cntR;
  logic signed [ACC_WIDTH-1:0]  accR;
  logic signed [ACC_WIDTH-1:0]  prodExt;
  logic signed [ACC_WIDTH-1:0]  sumW;
  logic signed [DATA_WIDTH-1:0] prodR;
  logic signed [DATA_WIDTH-1:0] prodNext;
  logic signed [HALF-1:0]       opA;
  logic signed [HALF-1:0]       opB;
  logic                         prodValidR;
  logic                         ovfR;
  logic                         rdReadyR;
  logic                         accept;
  logic                         addOvf;

  assign opA      = rdDataIn[DATA_WIDTH-1:HALF];
  assign opB      = rdDataIn[HALF-1:0];
  assign prodNext = DATA_WIDTH'(opA) * DATA_WIDTH'(opB);
  assign prodExt  = ACC_WIDTH'(prodR);
  assign sumW     = accR + prodExt;

  // Same-sign operands producing an opposite-sign sum.
  assign addOvf = (accR[ACC_WIDTH-1] == prodExt[ACC_WIDTH-1]) &&
                  (sumW[ACC_WIDTH-1] != accR[ACC_WIDTH-1]);

  assign rdReadyOut  = rdReadyR;
  assign accept      = rdValidIn & rdReadyR;
  assign busyOut     = (stateR != IDLE);
  assign resValidOut = (stateR == DONE);
  assign resDataOut  = resValidOut ? accR : '0;
  assign ovfOut      = resValidOut & ovfR;

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      stateR <= IDLE;
    end else begin
      stateR <= stateNext;
    end
  end

  // FLUSH lingers until the last product has been folded in.
  always_comb begin
    stateNext = stateR;
    unique case (stateR)
      IDLE: begin
        if (startIn) begin
          stateNext = (lenIn == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && cntR == LEN_WIDTH'(1)) begin
          stateNext = FLUSH;
        end
      end
      FLUSH: begin
        if (!prodValidR) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (resReadyIn) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      rdReadyR   <= 1'b0;
      cntR       <= '0;
      accR       <= '0;
      prodR      <= '0;
      prodValidR <= 1'b0;
      ovfR       <= 1'b0;
    end else begin
      rdReadyR <= (stateNext == ACCUM);
      if (stateR == IDLE) begin
        if (startIn) begin
          cntR       <= lenIn;
          accR       <= '0;
          prodR      <= '0;
          prodValidR <= 1'b0;
          ovfR       <= 1'b0;
        end
      end else begin
        prodValidR <= accept;
        if (accept) begin
          prodR <= prodNext;
          cntR  <= cntR - LEN_WIDTH'(1);
        end
        if (prodValidR) begin
          accR <= sumW;
          if (addOvf) begin
            ovfR <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_product_stage.sv
// Bench for dot_product_stage: a 48-bit and a 32-bit accumulator instance
// share one FIFO model and are checked against hand-computed results.
module tb_dot_product_stage;

  logic        clkIn = 1'b0;
  logic        rstIn;
  logic        startIn;
  logic [15:0] lenIn;
  logic [31:0] rdDataIn;
  logic        rdValidIn;
  logic        resReadyIn;

  logic        busy48, rdy48, val48, ovf48;
  logic [47:0] res48;
  logic        busy32, rdy32, val32, ovf32;
  logic [31:0] res32;

  always #5 clkIn = ~clkIn;

  dot_product_stage #(.DATA_WIDTH(32), .ACC_WIDTH(48), .LEN_WIDTH(16)) dut48 (
    .clkIn(clkIn), .rstIn(rstIn), .startIn(startIn), .lenIn(lenIn),
    .busyOut(busy48), .rdDataIn(rdDataIn), .rdValidIn(rdValidIn),
    .rdReadyOut(rdy48), .resDataOut(res48), .resValidOut(val48),
    .resReadyIn(resReadyIn), .ovfOut(ovf48)
  );

  dot_product_stage #(.DATA_WIDTH(32), .ACC_WIDTH(32), .LEN_WIDTH(16)) dut32 (
    .clkIn(clkIn), .rstIn(rstIn), .startIn(startIn), .lenIn(lenIn),
    .busyOut(busy32), .rdDataIn(rdDataIn), .rdValidIn(rdValidIn),
    .rdReadyOut(rdy32), .resDataOut(res32), .resValidOut(val32),
    .resReadyIn(resReadyIn), .ovfOut(ovf32)
  );

  typedef struct {
    int               len;
    logic [3:0][31:0] words;
    logic [47:0]      exp48;
    logic             eovf48;
    logic [31:0]      exp32;
    logic             eovf32;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] fifo[$];
  bit          gateValid = 1'b1;
  bit          rdySeen;
  bit          rdyAtEmpty;
  int          nTests = 0;
  int          nFail = 0;
  int          cyc = 0;
  int          acceptCnt;
  int          firstAcc;
  int          lastAcc;

  function automatic logic [31:0] pack(input int a, input int b);
    logic [15:0] ha;
    logic [15:0] hb;
    ha = a[15:0];
    hb = b[15:0];
    return {ha, hb};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    rdValidIn = gateValid && (fifo.size() > 0);
    rdDataIn  = (fifo.size() > 0) ? fifo[0] : '0;
  endtask

  task automatic tick();
    bit acc;
    acc = rdValidIn && rdy48;
    @(posedge clkIn);
    #1;
    cyc++;
    if (acc) begin
      void'(fifo.pop_front());
      if (acceptCnt == 0) firstAcc = cyc;
      acceptCnt++;
      lastAcc = cyc;
      if (fifo.size() == 0) rdyAtEmpty = rdy48;
    end
    if (rdy48) rdySeen = 1'b1;
    drive();
  endtask

  task automatic startJob(input int len);
    acceptCnt  = 0;
    rdySeen    = 1'b0;
    rdyAtEmpty = 1'b0;
    startIn    = 1'b1;
    lenIn      = 16'(len);
    tick();
    startIn    = 1'b0;
  endtask

  task automatic waitRes(input int bound);
    int n;
    n = 0;
    while (!val48 && n < bound) begin
      tick();
      n++;
    end
    if (!val48) chk("result_timeout", 64'(val48), 64'd1);
  endtask

  task automatic handoff(input string nm);
    resReadyIn = 1'b1;
    tick();
    resReadyIn = 1'b0;
    chk({nm, "_busy_after"}, 64'(busy48), 64'd0);
    chk({nm, "_valid_after"}, 64'(val48), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstIn      = 1'b0;
    startIn    = 1'b0;
    lenIn      = '0;
    resReadyIn = 1'b0;
    acceptCnt  = 0;
    drive();

    vecs[0].len = 3;
    vecs[0].words[0] = pack(3, 4);
    vecs[0].words[1] = pack(-2, 5);
    vecs[0].words[2] = pack(7, -1);
    vecs[0].words[3] = '0;
    vecs[0].exp48 = 48'hFFFF_FFFF_FFFB; vecs[0].eovf48 = 1'b0;
    vecs[0].exp32 = 32'hFFFF_FFFB;      vecs[0].eovf32 = 1'b0;

    vecs[1].len = 2;
    vecs[1].words[0] = pack(-32768, -32768);
    vecs[1].words[1] = pack(-32768, -32768);
    vecs[1].words[2] = '0;
    vecs[1].words[3] = '0;
    vecs[1].exp48 = 48'h0000_8000_0000; vecs[1].eovf48 = 1'b0;
    vecs[1].exp32 = 32'h8000_0000;      vecs[1].eovf32 = 1'b1;

    vecs[2].len = 1;
    vecs[2].words[0] = pack(1, 1);
    vecs[2].words[1] = '0;
    vecs[2].words[2] = '0;
    vecs[2].words[3] = '0;
    vecs[2].exp48 = 48'd1; vecs[2].eovf48 = 1'b0;
    vecs[2].exp32 = 32'd1; vecs[2].eovf32 = 1'b0;

    vecs[3].len = 4;
    for (int k = 0; k < 4; k++) vecs[3].words[k] = pack(32767, 32767);
    vecs[3].exp48 = 48'h0000_FFFC_0004; vecs[3].eovf48 = 1'b0;
    vecs[3].exp32 = 32'hFFFC_0004;      vecs[3].eovf32 = 1'b1;

    vecs[4].len = 2;
    vecs[4].words[0] = pack(-32768, 32767);
    vecs[4].words[1] = pack(-32768, 32767);
    vecs[4].words[2] = '0;
    vecs[4].words[3] = '0;
    vecs[4].exp48 = 48'hFFFF_8001_0000; vecs[4].eovf48 = 1'b0;
    vecs[4].exp32 = 32'h8001_0000;      vecs[4].eovf32 = 1'b0;

    #3;
    chk("reset_busy", 64'(busy48), 64'd0);
    chk("reset_rdy", 64'(rdy48), 64'd0);
    chk("reset_valid", 64'(val48), 64'd0);
    chk("reset_data", 64'(res48), 64'd0);
    chk("reset_ovf", 64'(ovf48), 64'd0);
    tick();
    tick();
    rstIn = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      fifo.delete();
      for (int k = 0; k < vecs[i].len; k++) fifo.push_back(vecs[i].words[k]);
      drive();
      startJob(vecs[i].len);
      chk($sformatf("v%0d_busy", i), 64'(busy48), 64'd1);
      waitRes(40);
      chk($sformatf("v%0d_res48", i), 64'(res48), 64'(vecs[i].exp48));
      chk($sformatf("v%0d_ovf48", i), 64'(ovf48), 64'(vecs[i].eovf48));
      chk($sformatf("v%0d_res32", i), 64'(res32), 64'(vecs[i].exp32));
      chk($sformatf("v%0d_ovf32", i), 64'(ovf32), 64'(vecs[i].eovf32));
      chk($sformatf("v%0d_latency", i), 64'(cyc - lastAcc), 64'd2);
      chk($sformatf("v%0d_accepts", i), 64'(acceptCnt), 64'(vecs[i].len));
      handoff($sformatf("v%0d", i));
    end

    fifo.delete();
    fifo.push_back(pack(9, 9));
    drive();
    startJob(0);
    chk("len0_valid", 64'(val48), 64'd1);
    chk("len0_data", 64'(res48), 64'd0);
    chk("len0_ovf", 64'(ovf48), 64'd0);
    tick();
    chk("len0_rdy_never", 64'(rdySeen), 64'd0);
    chk("len0_fifo_left", 64'(fifo.size()), 64'd1);
    handoff("len0");

    fifo.delete();
    for (int k = 0; k < 5; k++) fifo.push_back(pack(1, 1));
    gateValid = 1'b1;
    drive();
    startJob(4);
    begin
      int n;
      n = 0;
      while (!val48 && n < 60) begin
        gateValid = ~gateValid;
        tick();
        n++;
      end
    end
    chk("bp_valid", 64'(val48), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        startIn = 1'b1;
        lenIn   = 16'd3;
      end
      tick();
      startIn = 1'b0;
      chk($sformatf("bp_hold%0d_data", k), 64'(res48), 64'd4);
      chk($sformatf("bp_hold%0d_valid", k), 64'(val48), 64'd1);
    end
    chk("bp_accepts", 64'(acceptCnt), 64'd4);
    chk("bp_fifo_left", 64'(fifo.size()), 64'd1);
    handoff("bp");
    gateValid = 1'b1;
    fifo.delete();
    drive();

    for (int k = 0; k < 6; k++) fifo.push_back(pack(5, 5));
    drive();
    startJob(4);
    begin
      int n;
      n = 0;
      while (acceptCnt < 2 && n < 20) begin
        tick();
        n++;
      end
    end
    chk("arst_two_accepts", 64'(acceptCnt), 64'd2);
    #2 rstIn = 1'b0;
    #1;
    chk("arst_busy", 64'(busy48), 64'd0);
    chk("arst_rdy", 64'(rdy48), 64'd0);
    chk("arst_valid", 64'(val48), 64'd0);
    chk("arst_data", 64'(res48), 64'd0);
    chk("arst_ovf", 64'(ovf48), 64'd0);
    tick();
    rstIn = 1'b1;
    tick();
    fifo.delete();
    fifo.push_back(pack(-1, -1));
    drive();
    startJob(1);
    waitRes(20);
    chk("arst_next_res48", 64'(res48), 64'd1);
    chk("arst_next_res32", 64'(res32), 64'd1);
    chk("arst_next_ovf", 64'(ovf48), 64'd0);
    handoff("arst");

    fifo.delete();
    for (int i = 0; i < 16; i++) fifo.push_back(pack(i, 2));
    drive();
    startJob(16);
    begin
      int startCyc;
      startCyc = cyc;
      waitRes(60);
      chk("int_first_accept", 64'(firstAcc - startCyc), 64'd1);
    end
    chk("int_res", 64'(res48), 64'd240);
    chk("int_accepts", 64'(acceptCnt), 64'd16);
    chk("int_streaming", 64'(lastAcc - firstAcc), 64'd15);
    chk("int_fifo_empty", 64'(fifo.size()), 64'd0);
    chk("int_rdy_low_at_empty", 64'(rdyAtEmpty), 64'd0);
    handoff("int");

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/dot_product_stage.md
# dot_product_stage

Streaming signed multiply-accumulate stage that drains the read side of the accelerator's data FIFO. Each FIFO word carries a packed pair of signed operands. The stage multiplies each pair and accumulates the products over a software-programmed vector length. It then presents one result word on a valid/ready output handshake, which feeds the writeback/register path.

## Interface
- DATA_WIDTH, 32, FIFO word width; must be even; each operand is DATA_WIDTH/2 bits signed
- ACC_WIDTH, 48, accumulator/result width; must be >= DATA_WIDTH
- LEN_WIDTH, 16, width of the vector length field

- clkIn  input  1  single clock, all logic on rising edge
- rstIn  input  1  reset, asynchronous assert, active-low (0 = reset)
- startIn  input  1  job start pulse; sampled only in IDLE
- lenIn  input  LEN_WIDTH  number of FIFO words in the job, sampled with startIn
- busyOut  output  1  high whenever state != IDLE
- rdDataIn  input  DATA_WIDTH  FIFO read data; a = [DATA_WIDTH-1:DATA_WIDTH/2], b = [DATA_WIDTH/2-1:0]
- rdValidIn  input  1  FIFO read valid
- rdReadyOut  output  1  consume strobe to FIFO
- resDataOut  output  ACC_WIDTH  accumulated result, two's complement
- resValidOut  output  1  result valid
- resReadyIn  input  1  result accepted by downstream
- ovfOut  output  1  signed accumulator overflow occurred during this job; valid with resValidOut

## Operation
- States: IDLE, ACCUM, FLUSH, DONE.
- IDLE:
  - rdReadyOut=0.
  - startIn=1 with lenIn!=0: latch remaining count = lenIn, clear accR, prodR, prodValidR and ovf, then go to ACCUM.
  - startIn=1 with lenIn==0: clear accR and ovf, then go to DONE. The result is 0.
- ACCUM:
  - rdReadyOut=1.
  - A beat is accepted on an edge where rdValidIn & rdReadyOut.
  - On an accepted beat: prodR <= signed(a)*signed(b), which is DATA_WIDTH bits wide, and prodValidR <= 1. The remaining count decrements.
  - When no beat is accepted, prodValidR <= 0.
  - Every edge with prodValidR=1: accR <= accR + sext(prodR), wrapping modulo 2^ACC_WIDTH.
  - Overflow on an add sets ovf, which is sticky: both operands have the same sign and the sum has the opposite sign.
  - Accepting the beat with remaining count == 1 moves the state to FLUSH.
- FLUSH:
  - rdReadyOut=0.
  - The last prodR is accumulated, and the state goes to DONE.
- DONE:
  - resValidOut=1, resDataOut=accR, ovfOut=ovf, all held stable.
  - When resReadyIn=1, go to IDLE.
- startIn is ignored outside IDLE. lenIn is don't-care outside the start edge.
- rdReadyOut is registered: it goes high on the edge entering ACCUM and low on the edge that accepts the last beat. A word beyond lenIn is therefore never consumed.
- The FIFO presents rdDataIn and rdValidIn from registers, so no combinational path from rdValidIn to rdReadyOut is permitted.

## Timing
- Reset (rstIn=0):
  - Asynchronously forces state=IDLE and clears count, accR, prodR, prodValidR and ovf.
  - All outputs read 0: busyOut, rdReadyOut, resValidOut, resDataOut, ovfOut.
  - Reset mid-job discards the job; already-consumed FIFO words are lost.
  - Release is synchronous to clkIn.
- Start to first accept: startIn sampled at edge S, so rdReadyOut=1 in cycle S+1. The first accept can occur at edge S+1.
- Throughput: one word per cycle while rdValidIn stays high.
- Latency: last beat accepted at edge k gives accR final after edge k+2, with resValidOut=1 from edge k+2.
- len==0: resValidOut=1 one cycle after the start edge.
- Result hold: resDataOut and ovfOut are held stable while resValidOut=1 and resReadyIn=0, for any duration.
- Result handoff: a result accepted at edge R gives resValidOut=0 and busyOut=0 after R. A new startIn is honoured at edge R+1 or later.
- busyOut rises on the start edge and falls on the result-accept edge.

## Test plan
- Basic job, len=3, words (a,b)=(3,4),(-2,5),(7,-1), rdValidIn constant 1 -> resDataOut=48'hFFFF_FFFF_FFFB (-5), ovfOut=0, and resValidOut exactly 2 cycles after the 3rd accept.
- len=0 start -> resValidOut=1 next cycle, resDataOut=0, rdReadyOut never asserted, no FIFO word consumed.
- Backpressure, len=4 of (1,1), with rdValidIn toggling 1/0 and resReadyIn held 0 for 5 cycles after DONE -> result 4 stays stable throughout. A startIn pulse during DONE is ignored. Exactly 4 words are consumed, and a 5th FIFO word remains.
- Overflow with ACC_WIDTH=32, len=2 of (-32768,-32768) -> resDataOut=32'h8000_0000, ovfOut=1. The next job with len=1 of (1,1) -> result 1, ovfOut=0.
- Async reset, len=4, rstIn driven low between edges after 2 accepts -> all outputs 0 immediately, before the next clock edge. After release, a job with len=1 of (-1,-1) -> result 1 with no residue from the aborted job.
- Integration behind the FIFO, 16 words preloaded (a=i, b=2 for i=0..15), len=16 -> one accept per cycle, result 240, and the FIFO is empty at FLUSH.
